ftl_wbs_resp: RTL and testbench
===============================

// Module: ftl_wbs_resp
// PURPOSE
//  Responder for the SDHC-side block-cache requester: services wb_read/wb_write block-switch requests in the clk_50 domain.
//  Flushes the dirty cached block from cache BRAM (port B) to the logical store, loads the requested block, then signals done.
//  Sits between the cache BRAM and the FTL logical-store engine; four-phase wb_ack/wb_done handshake crosses clock domains.
// PARAMETERS
//  BLOCK_WORDS  NAND_BLOCK_SIZE/4  32-bit words per cached block; power of two, <=65536
// PORTS
//  clk_50         in   1   sole clock
//  reset_n        in   1   synchronous, active-low reset
//  wb_read        in   1   async level: switch to wb_block, clean
//  wb_write       in   1   async level: switch to wb_block, dirty
//  wb_block       in   10  async; stable while a request is high
//  wb_ack         out  1   request accepted; low only after request drops
//  wb_done        out  1   block resident in BRAM; held until request drops
//  bram_ftl_addr  out  16  cache BRAM port-B word address
//  bram_ftl_wren  out  1   port-B write enable
//  bram_ftl_data  out  32  port-B write data
//  bram_ftl_q     in   32  port-B read data, 1-cycle latency
//  ls_block       out  10  logical block for store op
//  ls_rd_req      out  1   load request, held until ls_done
//  ls_wr_req      out  1   flush request, held until ls_done
//  ls_wdata       out  32  flush word
//  ls_wvalid      out  1   flush word valid
//  ls_wready      in   1   store accepts flush word
//  ls_rdata       in   32  load word
//  ls_rvalid      in   1   load word valid (no backpressure)
//  ls_done        in   1   1-cycle pulse: store op complete
//  cached_block   out  10  resident block; 10'h3FF = none
//  dirty          out  1   resident block modified
// BEHAVIOUR
//  Reset: every output 0 except cached_block=10'h3FF; state IDLE; dirty data lost.
//  wb_read/wb_write pass through synch_3; wb_block sampled when synced request first seen in IDLE; both high -> write wins.
//  IDLE: synced request -> wb_ack=1, latch blk, op; dirty -> FL_ADDR, else LOAD_REQ.
//  FL_ADDR: ls_wr_req=1, ls_block=cached_block, drive addr cnt -> FL_WAIT (1 cycle) -> FL_PUSH: ls_wdata=q held, ls_wvalid=1 until ls_wready;
//   cnt+1; cnt==BLOCK_WORDS-1 accepted -> FL_DONE, else FL_ADDR. Throughput 1 word / 3 cycles min.
//  FL_DONE: wait ls_done (may arrive any cycle after last word; pulse before last word ignored); drop ls_wr_req next cycle; dirty=0 -> LOAD_REQ.
//  LOAD_REQ: ls_rd_req=1, ls_block=blk, cnt=0 -> LOAD: each ls_rvalid writes rdata at cnt, wren=1 same cycle; rvalid beyond BLOCK_WORDS ignored.
//  LOAD after BLOCK_WORDS words + ls_done -> COMPLETE; drop ls_rd_req. cached_block=blk.
//  COMPLETE: dirty=op_write; wb_done=1; when both synced requests low, wb_done=0 and wb_ack=0 same cycle -> IDLE.
//  Word counter width log2(BLOCK_WORDS)+1; bram_ftl_addr zero-extended; wraps never (bounded by count).
//  Request dropping mid-op: ignored, op completes, then handshake closes.
// CONFIGURATION
//  FTL_WBS_RESP_HIT_SKIP_EN defined: request with blk==cached_block skips flush+load -> COMPLETE in 1 cycle (write sets dirty=1).
//  Undefined: hit is treated as a miss: dirty block flushed and reloaded from store.
// STRUCTURE
//  ftl_const.vh: NAND_BLOCK_SIZE, invalid-block constant 10'h3FF, state encodings.
//  Reuse synch_3 for wb_read/wb_write; no further sub-module.
// TESTING (BLOCK_WORDS=8)
//  After reset: wb_read, blk 5 -> ls_rd_req, 8 words 0..7 to BRAM addr 0..7, wb_done; cached 5, dirty 0.
//  wb_write blk 5 (HIT_SKIP on) -> no ls_* activity, wb_done within 5 cycles, dirty 1.
//  wb_read blk 9, dirty 5 -> ls_wr_req blk 5, 8 BRAM words, wready toggling 1/0 -> exact order; then load 9; dirty 0.
//  Handshake: hold wb_read 20 cycles after wb_done -> wb_ack/wb_done held; drop -> both 0 within 4 cycles.
//  reset_n low during FL_PUSH word 3 -> all outputs reset next edge, cached 3FF, ls_wr_req 0.
//  Extra rvalid (9th word) and early ls_done -> no BRAM write at addr 8, no early wb_done.

Source files
------------

// File: rtl/ftl_wbs_resp_pkg.sv
// Shared constants and state encoding for the block-switch responder.
package ftl_wbs_resp_pkg;

    // NAND block size in bytes; the cache holds one block as 32-bit words.
    localparam int unsigned NAND_BLOCK_SIZE = 32'd2048;

    // cached_block value meaning "nothing resident".
    localparam logic [9:0] INVALID_BLOCK = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FL_ADDR  = 3'd1,
        ST_FL_WAIT  = 3'd2,
        ST_FL_PUSH  = 3'd3,
        ST_FL_DONE  = 3'd4,
        ST_LOAD_REQ = 3'd5,
        ST_LOAD     = 3'd6,
        ST_COMPLETE = 3'd7
    } state_e;

endpackage

// File: rtl/ftl_wbs_resp_synch_3.sv
// Three-flop resynchroniser for asynchronous level signals entering clk_50.
module ftl_wbs_resp_synch_3 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] s3_q;

    // Shift the asynchronous level through three stages to settle metastability
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
            s3_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q = s3_q;

endmodule

// File: rtl/ftl_wbs_resp.sv
// Block-switch responder: flushes the dirty cached block from cache BRAM
// port B to the logical store, loads the requested block, then signals done.
// Optional build macro FTL_WBS_RESP_HIT_SKIP_EN: a request for the block that
// is already resident completes immediately without store traffic.
module ftl_wbs_resp
    import ftl_wbs_resp_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = NAND_BLOCK_SIZE / 32'd4
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        wb_read,
    input  logic        wb_write,
    input  logic [9:0]  wb_block,
    output logic        wb_ack,
    output logic        wb_done,
    output logic [15:0] bram_ftl_addr,
    output logic        bram_ftl_wren,
    output logic [31:0] bram_ftl_data,
    input  logic [31:0] bram_ftl_q,
    output logic [9:0]  ls_block,
    output logic        ls_rd_req,
    output logic        ls_wr_req,
    output logic [31:0] ls_wdata,
    output logic        ls_wvalid,
    input  logic        ls_wready,
    input  logic [31:0] ls_rdata,
    input  logic        ls_rvalid,
    input  logic        ls_done,
    output logic [9:0]  cached_block,
    output logic        dirty
);

    // One extra bit so the counter can hold BLOCK_WORDS itself ("all loaded").
    localparam int unsigned   CW       = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_WORDS);

    logic [1:0] req_raw_s;
    logic [1:0] req_sync_s;
    logic       hit_s;

    state_e        state_q, state_d;
    logic          wb_ack_q, wb_ack_d;
    logic          wb_done_q, wb_done_d;
    logic [15:0]   addr_q, addr_d;
    logic          wren_q, wren_d;
    logic [31:0]   bram_data_q, bram_data_d;
    logic [9:0]    ls_block_q, ls_block_d;
    logic          ls_rd_req_q, ls_rd_req_d;
    logic          ls_wr_req_q, ls_wr_req_d;
    logic [31:0]   ls_wdata_q, ls_wdata_d;
    logic          ls_wvalid_q, ls_wvalid_d;
    logic [9:0]    cached_q, cached_d;
    logic          dirty_q, dirty_d;
    logic [9:0]    blk_q, blk_d;
    logic          op_write_q, op_write_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // bit 1 = write, bit 0 = read; write wins when both are seen
    assign req_raw_s = {wb_write, wb_read};

    ftl_wbs_resp_synch_3 #(.WIDTH(2)) u_req_sync (
        .clk     (clk_50),
        .reset_n (reset_n),
        .d       (req_raw_s),
        .q       (req_sync_s)
    );

`ifdef FTL_WBS_RESP_HIT_SKIP_EN
    assign hit_s = (wb_block == cached_q) && (cached_q != INVALID_BLOCK);
`else
    assign hit_s = 1'b0;
`endif

    // Next-state and next-output computation for the block-switch sequence
    always_comb begin
        state_d     = state_q;
        wb_ack_d    = wb_ack_q;
        wb_done_d   = wb_done_q;
        addr_d      = addr_q;
        wren_d      = 1'b0;
        bram_data_d = bram_data_q;
        ls_block_d  = ls_block_q;
        ls_rd_req_d = ls_rd_req_q;
        ls_wr_req_d = ls_wr_req_q;
        ls_wdata_d  = ls_wdata_q;
        ls_wvalid_d = ls_wvalid_q;
        cached_d    = cached_q;
        dirty_d     = dirty_q;
        blk_d       = blk_q;
        op_write_d  = op_write_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_sync_s != 2'b00) begin
                    wb_ack_d   = 1'b1;
                    blk_d      = wb_block;
                    op_write_d = req_sync_s[1];
                    if (hit_s) begin
                        dirty_d   = dirty_q | req_sync_s[1];
                        wb_done_d = 1'b1;
                        state_d   = ST_COMPLETE;
                    end else if (dirty_q) begin
                        // addr is presented during FL_ADDR so q is ready in FL_WAIT
                        cnt_d       = CNT_ZERO;
                        addr_d      = 16'd0;
                        ls_wr_req_d = 1'b1;
                        ls_block_d  = cached_q;
                        state_d     = ST_FL_ADDR;
                    end else begin
                        state_d = ST_LOAD_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FL_ADDR: begin
                state_d = ST_FL_WAIT;
            end
            ST_FL_WAIT: begin
                ls_wdata_d  = bram_ftl_q;
                ls_wvalid_d = 1'b1;
                state_d     = ST_FL_PUSH;
            end
            ST_FL_PUSH: begin
                if (ls_wready) begin
                    ls_wvalid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FL_DONE;
                    end else begin
                        addr_d  = 16'(cnt_q + CNT_ONE);
                        state_d = ST_FL_ADDR;
                    end
                end else begin
                    state_d = ST_FL_PUSH;
                end
            end
            ST_FL_DONE: begin
                if (ls_done) begin
                    ls_wr_req_d = 1'b0;
                    dirty_d     = 1'b0;
                    state_d     = ST_LOAD_REQ;
                end else begin
                    state_d = ST_FL_DONE;
                end
            end
            ST_LOAD_REQ: begin
                ls_rd_req_d = 1'b1;
                ls_block_d  = blk_q;
                cnt_d       = CNT_ZERO;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                // words beyond the block size are dropped, never written
                if (ls_rvalid && (cnt_q != CNT_FULL)) begin
                    wren_d      = 1'b1;
                    addr_d      = 16'(cnt_q);
                    bram_data_d = ls_rdata;
                    cnt_d       = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                // a done pulse before the block is complete is ignored
                if (ls_done && (cnt_d == CNT_FULL)) begin
                    ls_rd_req_d = 1'b0;
                    cached_d    = blk_q;
                    dirty_d     = op_write_q;
                    wb_done_d   = 1'b1;
                    state_d     = ST_COMPLETE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMPLETE: begin
                if (req_sync_s == 2'b00) begin
                    wb_done_d = 1'b0;
                    wb_ack_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_COMPLETE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wb_ack_q    <= 1'b0;
            wb_done_q   <= 1'b0;
            addr_q      <= 16'd0;
            wren_q      <= 1'b0;
            bram_data_q <= 32'd0;
            ls_block_q  <= 10'd0;
            ls_rd_req_q <= 1'b0;
            ls_wr_req_q <= 1'b0;
            ls_wdata_q  <= 32'd0;
            ls_wvalid_q <= 1'b0;
            cached_q    <= INVALID_BLOCK;
            dirty_q     <= 1'b0;
            blk_q       <= 10'd0;
            op_write_q  <= 1'b0;
            cnt_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            wb_ack_q    <= wb_ack_d;
            wb_done_q   <= wb_done_d;
            addr_q      <= addr_d;
            wren_q      <= wren_d;
            bram_data_q <= bram_data_d;
            ls_block_q  <= ls_block_d;
            ls_rd_req_q <= ls_rd_req_d;
            ls_wr_req_q <= ls_wr_req_d;
            ls_wdata_q  <= ls_wdata_d;
            ls_wvalid_q <= ls_wvalid_d;
            cached_q    <= cached_d;
            dirty_q     <= dirty_d;
            blk_q       <= blk_d;
            op_write_q  <= op_write_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wb_ack        = wb_ack_q;
    assign wb_done       = wb_done_q;
    assign bram_ftl_addr = addr_q;
    assign bram_ftl_wren = wren_q;
    assign bram_ftl_data = bram_data_q;
    assign ls_block      = ls_block_q;
    assign ls_rd_req     = ls_rd_req_q;
    assign ls_wr_req     = ls_wr_req_q;
    assign ls_wdata      = ls_wdata_q;
    assign ls_wvalid     = ls_wvalid_q;
    assign cached_block  = cached_q;
    assign dirty         = dirty_q;

endmodule

// File: tb/tb_ftl_wbs_resp.sv
// Self-checking bench for ftl_wbs_resp with BLOCK_WORDS=8: the bench plays the
// SDHC requester, the cache BRAM (both ports) and the logical store, and keeps
// a cache model (resident block, dirty flag, expected cache contents).
module tb_ftl_wbs_resp;

    localparam int BW = 8;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_read = 1'b0;
    logic        wb_write = 1'b0;
    logic [9:0]  wb_block = 10'd0;
    logic        wb_ack, wb_done;
    logic [15:0] bram_ftl_addr;
    logic        bram_ftl_wren;
    logic [31:0] bram_ftl_data;
    logic [31:0] bram_ftl_q;
    logic [9:0]  ls_block;
    logic        ls_rd_req, ls_wr_req;
    logic [31:0] ls_wdata;
    logic        ls_wvalid;
    logic        ls_wready = 1'b0;
    logic [31:0] ls_rdata = 32'd0;
    logic        ls_rvalid = 1'b0;
    logic        ls_done = 1'b0;
    logic [9:0]  cached_block;
    logic        dirty;

    int n_cmp = 0;
    int n_err = 0;

    // port A of the BRAM model (SDHC-side scribbles)
    logic        pa_we = 1'b0;
    logic [3:0]  pa_addr = 4'd0;
    logic [31:0] pa_data = 32'd0;
    logic [31:0] bram_mem [0:15];
    int          bad_wr = 0;

    // logical store and cache model
    logic [31:0] store_m [0:1023][0:BW-1];
    logic [31:0] exp_cache [0:BW-1];
    logic [9:0]  cached_m;
    bit          dirty_m;

    ftl_wbs_resp #(.BLOCK_WORDS(BW)) dut (
        .clk_50        (clk_50),
        .reset_n       (reset_n),
        .wb_read       (wb_read),
        .wb_write      (wb_write),
        .wb_block      (wb_block),
        .wb_ack        (wb_ack),
        .wb_done       (wb_done),
        .bram_ftl_addr (bram_ftl_addr),
        .bram_ftl_wren (bram_ftl_wren),
        .bram_ftl_data (bram_ftl_data),
        .bram_ftl_q    (bram_ftl_q),
        .ls_block      (ls_block),
        .ls_rd_req     (ls_rd_req),
        .ls_wr_req     (ls_wr_req),
        .ls_wdata      (ls_wdata),
        .ls_wvalid     (ls_wvalid),
        .ls_wready     (ls_wready),
        .ls_rdata      (ls_rdata),
        .ls_rvalid     (ls_rvalid),
        .ls_done       (ls_done),
        .cached_block  (cached_block),
        .dirty         (dirty)
    );

    always #5 clk_50 = ~clk_50;

    // BRAM model: port-B 1-cycle read latency, writes outside the block are flagged
    always @(posedge clk_50) begin
        if (pa_we) bram_mem[pa_addr] <= pa_data;
        if (bram_ftl_wren) begin
            if (bram_ftl_addr < 16'd8) bram_mem[bram_ftl_addr[3:0]] <= bram_ftl_data;
            else bad_wr <= bad_wr + 1;
        end
        bram_ftl_q <= bram_mem[bram_ftl_addr[3:0]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_flags"}, {wb_ack, wb_done, bram_ftl_wren, ls_rd_req, ls_wr_req, ls_wvalid, dirty}, 64'd0);
        check_eq({tag, "_addr_blk"}, {bram_ftl_addr, ls_block}, 64'd0);
        check_eq({tag, "_data"}, {bram_ftl_data, ls_wdata}, 64'd0);
        check_eq({tag, "_cached"}, cached_block, 64'h3FF);
    endtask

    task automatic apply_reset();
        @(negedge clk_50);
        reset_n = 1'b0; wb_read = 1'b0; wb_write = 1'b0;
        ls_wready = 1'b0; ls_rvalid = 1'b0; ls_done = 1'b0;
        repeat (3) @(negedge clk_50);
        check_reset_outs("reset");
        reset_n = 1'b1;
        cached_m = 10'h3FF;
        dirty_m  = 1'b0;
    endtask

    // One block-switch request, acting as requester and store; rst_word>=0
    // aborts with reset_n while that flush word is on offer.
    task automatic run_req(input bit wr, input logic [9:0] blk, input int hold, input int rst_word);
        bit hit, exp_flush, exp_load, exp_dirty;
        bit saw_wr, saw_rd, done_seen, fl_done_sent, ld_done_sent, extra_sent, early_fl, early_ld;
        bit held_ok, split;
        int flushed, sent, cyc, fl_delay, n;
        hit = 1'b0;
`ifdef FTL_WBS_RESP_HIT_SKIP_EN
        hit = (blk == cached_m) && (cached_m != 10'h3FF);
`endif
        exp_flush = dirty_m && !hit;
        exp_load  = !hit;
        exp_dirty = hit ? (dirty_m | wr) : wr;
        saw_wr = 0; saw_rd = 0; done_seen = 0; fl_done_sent = 0; ld_done_sent = 0;
        extra_sent = 0; early_fl = 0; early_ld = 0;
        flushed = 0; sent = 0; cyc = 0;
        fl_delay = $urandom_range(0, 3);

        @(negedge clk_50);
        wb_block = blk;
        wb_write = wr;
        wb_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;

        while (!done_seen && cyc < 3000) begin
            @(negedge clk_50);
            cyc++;
            ls_done = 1'b0;
            ls_rvalid = 1'b0;
            if (wb_done) begin
                done_seen = 1'b1;
                ls_wready = 1'b0;
            end else begin
                if (rst_word >= 0 && ls_wvalid && flushed == rst_word) begin
                    reset_n = 1'b0; wb_read = 1'b0; wb_write = 1'b0; ls_wready = 1'b0;
                    @(negedge clk_50);
                    check_reset_outs("midflush");
                    reset_n = 1'b1;
                    cached_m = 10'h3FF;
                    dirty_m  = 1'b0;
                    return;
                end
                // flush side of the store
                if (ls_wr_req && !saw_wr) begin
                    saw_wr = 1'b1;
                    check_eq("fl_block", ls_block, cached_m);
                end
                if (flushed == BW && !fl_done_sent) begin
                    if (fl_delay == 0) begin ls_done = 1'b1; fl_done_sent = 1'b1; end
                    else fl_delay--;
                end
                ls_wready = (ls_wr_req && flushed < BW) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (ls_wvalid && ls_wready && flushed < BW) begin
                    check_eq("fl_word", ls_wdata, exp_cache[flushed]);
                    store_m[cached_m][flushed] = ls_wdata;
                    flushed++;
                end else if (ls_wr_req && flushed == 2 && !early_fl) begin
                    ls_done = 1'b1;
                    early_fl = 1'b1;
                end
                // load side of the store
                if (ls_rd_req && !saw_rd) begin
                    saw_rd = 1'b1;
                    check_eq("ld_block", ls_block, blk);
                    check_eq("ld_after_flush", flushed, exp_flush ? BW : 0);
                end
                if (saw_rd && !ld_done_sent) begin
                    if (sent < BW) begin
                        if ($urandom_range(0, 2) != 0) begin
                            ls_rvalid = 1'b1;
                            ls_rdata  = store_m[blk][sent];
                            sent++;
                        end else if (sent >= 1 && sent <= BW - 2 && !early_ld) begin
                            ls_done  = 1'b1;
                            early_ld = 1'b1;
                        end
                    end else if (!extra_sent) begin
                        ls_rvalid  = 1'b1;
                        ls_rdata   = $urandom;
                        extra_sent = 1'b1;
                    end else begin
                        ls_done = 1'b1;
                        ld_done_sent = 1'b1;
                    end
                end
            end
        end

        check_eq("done_seen", done_seen, 1);
        if (!done_seen) begin
            apply_reset();
            return;
        end
        check_eq("ack_at_done", wb_ack, 1);
        check_eq("flush_seen", saw_wr, exp_flush);
        check_eq("flush_words", flushed, exp_flush ? BW : 0);
        check_eq("load_seen", saw_rd, exp_load);
        check_eq("load_words", sent, exp_load ? BW : 0);
        check_eq("cached", cached_block, blk);
        check_eq("dirty", dirty, exp_dirty);

        // handshake stays up while the request is held
        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_50);
            held_ok = held_ok & wb_ack & wb_done;
        end
        check_eq("hs_held", held_ok, 1);
        wb_read = 1'b0;
        wb_write = 1'b0;
        split = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk_50);
            n++;
            if (wb_ack != wb_done) split = 1'b1;
            if (!wb_ack && !wb_done) break;
        end
        check_eq("hs_close_le4", (n <= 4), 1);
        check_eq("hs_close_together", split, 0);

        // update cache model, then compare BRAM contents and stray writes
        if (exp_load) begin
            for (int i = 0; i < BW; i++) exp_cache[i] = store_m[blk][i];
        end
        cached_m = blk;
        dirty_m  = exp_dirty;
        for (int i = 0; i < BW; i++) check_eq("bram_word", bram_mem[i], exp_cache[i]);
        check_eq("no_write_past_block", bad_wr, 0);

        // a write request means the SDHC side modifies the resident block
        if (wr) begin
            for (int i = 0; i < BW; i++) begin
                @(negedge clk_50);
                pa_we = 1'b1;
                pa_addr = 4'(i);
                pa_data = $urandom;
                exp_cache[i] = pa_data;
            end
            @(negedge clk_50);
            pa_we = 1'b0;
        end
    endtask

    initial begin
        for (int b = 0; b < 1024; b++)
            for (int w = 0; w < BW; w++) store_m[b][w] = $urandom;
        for (int w = 0; w < BW; w++) store_m[5][w] = 32'(w);
        for (int w = 0; w < BW; w++) exp_cache[w] = 32'd0;
        cached_m = 10'h3FF;
        dirty_m  = 1'b0;

        apply_reset();

        // directed sequence
        run_req(1'b0, 10'd5, 2, -1);
        run_req(1'b1, 10'd5, 3, -1);
        run_req(1'b0, 10'd9, 20, -1);
        run_req(1'b1, 10'd3, 1, -1);
        run_req(1'b0, 10'd7, 0, 3);
        repeat (4) @(negedge clk_50);
        run_req(1'b1, 10'd12, 2, -1);

        // randomized sequence, biased towards re-requesting the resident block
        for (int k = 0; k < 25; k++) begin
            logic [9:0] rb;
            bit rw;
            rw = 1'($urandom_range(0, 1));
            if (cached_m != 10'h3FF && $urandom_range(0, 2) == 0) rb = cached_m;
            else rb = 10'($urandom_range(0, 1022));
            run_req(rw, rb, $urandom_range(0, 6), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
